// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a hardware return stack.
// All state advances on the falling edge of WCLOCK.
//
// Ports:
//   WCLOCK  - sole clock, state updates on falling edge
//   RESET   - synchronous active-high reset
//   EN      - advance enable (0 holds all state)
//   OP      - 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 reserved (hold)
//   COND    - qualifies JUMP/BRANCH
//   IADDR   - absolute target for JUMP/CALL
//   OFFSET  - two's-complement offset for BRANCH
//   OADDR   - current program address (registered)
//   DEPTH   - occupied return-stack entries
//   FULL    - DEPTH == STACK_DEPTH
//   EMPTY   - DEPTH == 0
//   OVF/UNF - sticky stack overflow / underflow flags
module pc_sequencer #(
  parameter int unsigned            ADDR_WIDTH  = 11,
  parameter int unsigned            STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0
) (
  input  logic                                 WCLOCK,
  input  logic                                 RESET,
  input  logic                                 EN,
  input  logic [2:0]                           OP,
  input  logic                                 COND,
  input  logic [ADDR_WIDTH-1:0]                IADDR,
  input  logic [ADDR_WIDTH-1:0]                OFFSET,
  output logic [ADDR_WIDTH-1:0]                OADDR,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     DEPTH,
  output logic                                 FULL,
  output logic                                 EMPTY,
  output logic                                 OVF,
  output logic                                 UNF
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]         r_depth;
  logic                  r_ovf;
  logic                  r_unf;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] w_inc_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_top;
  logic [PW-1:0]         w_wr_idx;
  logic [PW-1:0]         w_top_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_hold;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_set_ovf;
  logic                  w_set_unf;

  // Stack occupancy status
  assign w_full  = (r_depth == DW'(STACK_DEPTH));
  assign w_empty = (r_depth == DW'(0));

  // Write slot is the next free entry; top is the last written. When the
  // stack is empty w_top_idx is meaningless but never consumed.
  assign w_wr_idx   = PW'(r_depth);
  assign w_top_idx  = PW'(r_depth - DW'(1));
  assign w_top      = r_stack[w_top_idx];
  assign w_inc_addr = r_addr + ADDR_WIDTH'(1);

  // Operation decode; addition wraps naturally, so signed BRANCH offsets
  // reduce to a plain modular add.
  always_comb begin
    w_next_addr = w_inc_addr;
    w_hold      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    case (OP)
      OP_INC: begin
        w_next_addr = w_inc_addr;
      end
      OP_JUMP: begin
        if (COND) w_next_addr = IADDR;
      end
      OP_BRANCH: begin
        if (COND) w_next_addr = r_addr + OFFSET;
      end
      OP_CALL: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_next_addr = IADDR;
        end else begin
          w_set_ovf = 1'b1;
        end
      end
      OP_RET: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_next_addr = w_top;
        end else begin
          w_set_unf = 1'b1;
        end
      end
      default: begin
        w_hold = 1'b1;
      end
    endcase
  end

  // Address, depth and sticky flags
  always_ff @(negedge WCLOCK) begin
    if (RESET) begin
      r_addr  <= RESET_ADDR;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (EN && !w_hold) begin
      r_addr <= w_next_addr;
      if (w_push) r_depth <= r_depth + DW'(1);
      if (w_pop)  r_depth <= r_depth - DW'(1);
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  // Return-stack storage; contents survive reset but become unreachable.
  always_ff @(negedge WCLOCK) begin
    if (!RESET && EN && w_push) begin
      r_stack[w_wr_idx] <= w_inc_addr;
    end
  end

  assign OADDR = r_addr;
  assign DEPTH = r_depth;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks of pc_sequencer against
// a queue-based reference model of the program counter and return stack.
module tb_pc_sequencer;

  localparam int unsigned AW   = 11;
  localparam int unsigned SD   = 8;
  localparam int unsigned DW   = $clog2(SD + 1);
  localparam int unsigned MASK = (1 << AW) - 1;
  localparam int unsigned RST_ADDR = 0;

  logic          WCLOCK;
  logic          RESET;
  logic          EN;
  logic [2:0]    OP;
  logic          COND;
  logic [AW-1:0] IADDR;
  logic [AW-1:0] OFFSET;
  logic [AW-1:0] OADDR;
  logic [DW-1:0] DEPTH;
  logic          FULL;
  logic          EMPTY;
  logic          OVF;
  logic          UNF;

  pc_sequencer #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (SD),
    .RESET_ADDR  (AW'(RST_ADDR))
  ) dut (
    .WCLOCK (WCLOCK),
    .RESET  (RESET),
    .EN     (EN),
    .OP     (OP),
    .COND   (COND),
    .IADDR  (IADDR),
    .OFFSET (OFFSET),
    .OADDR  (OADDR),
    .DEPTH  (DEPTH),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .OVF    (OVF),
    .UNF    (UNF)
  );

  initial begin
    WCLOCK = 1'b1;
    forever #5 WCLOCK = ~WCLOCK;
  end

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model state
  int unsigned m_addr;
  int unsigned m_stack[$];
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int unsigned op,
                            input bit cond, input int unsigned ia, input int unsigned off);
    if (rst) begin
      m_addr = RST_ADDR;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (en) begin
      case (op)
        0: m_addr = (m_addr + 1) & MASK;
        1: m_addr = cond ? ia : ((m_addr + 1) & MASK);
        2: m_addr = cond ? ((m_addr + off) & MASK) : ((m_addr + 1) & MASK);
        3: begin
          if (m_stack.size() < SD) begin
            m_stack.push_back((m_addr + 1) & MASK);
            m_addr = ia;
          end else begin
            m_addr = (m_addr + 1) & MASK;
            m_ovf = 1;
          end
        end
        4: begin
          if (m_stack.size() > 0) m_addr = m_stack.pop_back();
          else begin
            m_addr = (m_addr + 1) & MASK;
            m_unf = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("oaddr", OADDR, m_addr);
    check("depth", DEPTH, m_stack.size());
    check("full",  FULL,  (m_stack.size() == SD) ? 1 : 0);
    check("empty", EMPTY, (m_stack.size() == 0) ? 1 : 0);
    check("ovf",   OVF,   m_ovf);
    check("unf",   UNF,   m_unf);
  endtask

  // Drive one edge worth of inputs, let the falling edge happen, then compare.
  task automatic step(input bit rst, input bit en, input int unsigned op,
                      input bit cond, input int unsigned ia, input int unsigned off);
    RESET  = rst;
    EN     = en;
    OP     = 3'(op);
    COND   = cond;
    IADDR  = AW'(ia);
    OFFSET = AW'(off);
    @(negedge WCLOCK);
    model_step(rst, en, op, cond, ia, off);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_addr = 0;
    m_ovf = 0;
    m_unf = 0;
    RESET = 1; EN = 0; OP = 3'd0; COND = 0; IADDR = '0; OFFSET = '0;

    // Reset then three increments
    do_reset();
    check("rst_oaddr", OADDR, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full",  FULL,  0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, $urandom_range(0, 1), $urandom, 0);
      check("inc_seq", OADDR, i);
    end

    // Wrap and signed branch
    step(0, 1, 1, 1, 'h7FF, 0);
    step(0, 1, 0, 0, 0, 0);
    check("inc_wrap", OADDR, 'h000);
    step(0, 1, 1, 1, 'h005, 0);
    step(0, 1, 2, 1, 0, 'h7FD);
    check("branch_neg", OADDR, 'h002);
    step(0, 1, 1, 1, 'h005, 0);
    step(0, 1, 2, 0, 0, 'h7FD);
    check("branch_nc", OADDR, 'h006);
    step(0, 1, 1, 0, 'h300, 0);
    check("jump_nc", OADDR, 'h007);

    // Single call/return
    step(0, 1, 1, 1, 'h010, 0);
    step(0, 1, 3, 0, 'h100, 0);
    check("call_addr",  OADDR, 'h100);
    check("call_depth", DEPTH, 1);
    step(0, 1, 4, 1, 'h555, 0);
    check("ret_addr",  OADDR, 'h011);
    check("ret_empty", EMPTY, 1);

    // Fill, overflow, drain, underflow
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 3, $urandom_range(0, 1), 'h100 + i * 'h10, 0);
      if (i == 7) check("full_at8", FULL, 1);
    end
    check("ovf_addr",  OADDR, 'h171);
    check("ovf_flag",  OVF, 1);
    check("ovf_depth", DEPTH, 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4, 0, 0, 0);
      check("ret_order", OADDR, (i == 7) ? 'h001 : ('h161 - i * 'h10));
    end
    step(0, 1, 4, 0, 0, 0);
    check("unf_flag", UNF, 1);
    check("unf_addr", OADDR, 'h002);

    // Hold with EN=0 and reserved opcode
    step(0, 0, 1, 1, 'h444, 0);
    check("hold_en", OADDR, 'h002);
    step(0, 1, 6, 1, 'h444, 0);
    check("hold_rsv", OADDR, 'h002);
    check("hold_unf", UNF, 1);

    // Reset with depth 5 and OVF set, OP=CALL
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 1, 3, 0, 'h200 + i, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 4, 0, 0, 0);
    check("pre_depth", DEPTH, 5);
    check("pre_ovf",   OVF, 1);
    step(1, 1, 3, 1, 'h123, 0);
    check("rst_mid_addr",  OADDR, RST_ADDR);
    check("rst_mid_depth", DEPTH, 0);
    check("rst_mid_ovf",   OVF, 0);
    check("rst_mid_unf",   UNF, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      int unsigned op;
      r = $urandom_range(0, 99);
      if      (r < 20) op = 0;
      else if (r < 30) op = 1;
      else if (r < 45) op = 2;
      else if (r < 70) op = 3;
      else if (r < 92) op = 4;
      else             op = $urandom_range(5, 7);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), op,
           $urandom_range(0, 1), $urandom & MASK, $urandom & MASK);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, address width in bits.
REQ-002 Parameter STACK_DEPTH, default 8, return-stack entries (>=2).
REQ-003 Parameter RESET_ADDR, default 0, OADDR value after reset.
REQ-004 WCLOCK  input  1  sole clock; all state SHALL update on the falling edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  advance enable; 0 = hold all state.
REQ-007 OP  input  3  operation: 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 reserved.
REQ-008 COND  input  1  condition qualifying JUMP/BRANCH.
REQ-009 IADDR  input  ADDR_WIDTH  absolute target for JUMP/CALL.
REQ-010 OFFSET  input  ADDR_WIDTH  two's-complement relative offset for BRANCH.
REQ-011 OADDR  output  ADDR_WIDTH  current program address (registered).
REQ-012 DEPTH  output  $clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-013 FULL / EMPTY  output  1 each  DEPTH==STACK_DEPTH / DEPTH==0 (combinational from DEPTH).
REQ-014 OVF / UNF  output  1 each  sticky stack overflow / underflow flags.

Function
REQ-015 Priority per edge SHALL be: RESET > EN==0 (hold) > OP decode.
REQ-016 INC: OADDR <= OADDR+1.
REQ-017 JUMP: COND=1 -> OADDR <= IADDR; COND=0 -> INC.
REQ-018 BRANCH: COND=1 -> OADDR <= OADDR+OFFSET (signed); COND=0 -> INC.
REQ-019 CALL, not FULL: push OADDR+1, OADDR <= IADDR, DEPTH+1.
REQ-020 CALL, FULL: no push, DEPTH unchanged, OADDR <= OADDR+1, OVF <= 1.
REQ-021 RET, not EMPTY: OADDR <= top entry, pop, DEPTH-1.
REQ-022 RET, EMPTY: OADDR <= OADDR+1, DEPTH stays 0, UNF <= 1.
REQ-023 Reserved OP 5-7: hold all state, no flag change.
REQ-024 All address arithmetic (INC, BRANCH, pushed return address) SHALL wrap modulo 2^ADDR_WIDTH, no saturation or flag.
REQ-025 COND SHALL be ignored for INC, CALL, RET.
REQ-026 Stack is LIFO; entries below top SHALL be unaffected by push/pop of top.
REQ-027 Latency: every change to OADDR/DEPTH/flags SHALL be visible one falling edge after the qualifying inputs; no combinational path from inputs to OADDR.
REQ-028 OVF/UNF SHALL remain set until RESET; EN==0 does not clear them.

Reset
REQ-029 On a falling edge with RESET=1: OADDR <= RESET_ADDR, DEPTH <= 0, OVF <= 0, UNF <= 0, regardless of EN/OP.
REQ-030 Reset mid-sequence SHALL discard all stack contents; stack RAM contents need not be cleared but SHALL be unreachable (EMPTY=1).
REQ-031 After reset: FULL=0, EMPTY=1.

Verification
REQ-032 Reset then 3 edges EN=1 OP=INC -> OADDR 0,1,2,3; DEPTH=0, EMPTY=1.
REQ-033 OADDR=0x7FF, OP=INC -> OADDR=0x000; OADDR=0x005, BRANCH COND=1 OFFSET=0x7FD (-3) -> 0x002; COND=0 -> 0x006.
REQ-034 OADDR=0x010, CALL IADDR=0x100 -> OADDR=0x100, DEPTH=1; RET -> OADDR=0x011, DEPTH=0, EMPTY=1.
REQ-035 9 consecutive CALLs (depth 8) -> FULL after 8th, 9th gives OADDR=prev+1, OVF=1, DEPTH=8; 8 RETs return addresses in reverse order; 9th RET -> UNF=1, OADDR increments.
REQ-036 EN=0 with OP=JUMP COND=1 -> OADDR, DEPTH, flags unchanged; OP=6 with EN=1 -> unchanged.
REQ-037 RESET=1 asserted with DEPTH=5, OVF=1, OP=CALL -> OADDR=RESET_ADDR, DEPTH=0, OVF=0, UNF=0 next edge.
